// File: rtl/analog_sar_adc_3v3.sv
// analog_sar_adc_3v3
// Behavioural 3.3 V successive-approximation ADC. The analog input and both
// references arrive as real values. Each conversion samples VIN once and then
// resolves one bit per clock, MSB first, against a real-valued trial level.
//
// Optional build macro: ANALOG_ADC_CONT_EN
//   undefined : single-shot, one START per conversion.
//   defined   : continuous mode, resamples VIN at every last-bit edge while EN=1.
//
// Handshake: VALID is a one-cycle pulse and means DATA changed on that edge.
// There is no ready/backpressure; a consumer must take DATA on the VALID cycle
// or read the held DATA later. START is a level sampled only while idle, and a
// START seen during a conversion is dropped.
//
// NBITS must lie in 4..16.
module analog_sar_adc_3v3 #(
  parameter int NBITS = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             EN,
  input  logic             START,
  input  real              VIN,
  input  real              VREFH,
  input  real              VREFL,
  output logic [NBITS-1:0] DATA,
  output logic             VALID,
  output logic             BUSY,
  output logic             dbg_state
);

  localparam int IW = $clog2(NBITS);
  localparam logic [IW-1:0] IDX_MSB = IW'(NBITS - 1);
  localparam int unsigned FULL = 32'd1 << NBITS;
  localparam logic [NBITS-1:0] ONE = {{(NBITS-1){1'b0}}, 1'b1};

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  state_t           state;
  logic [NBITS-1:0] sar;
  logic [IW-1:0]    idx;
  real              vsamp;

  logic [NBITS-1:0] trial;
  logic [NBITS-1:0] sar_next;
  real              vtrial;
  logic             keep_bit;

  // Debug view of the sequencer for external checkers.
  assign dbg_state = state;

  // Trial level for the bit under test; a NaN anywhere makes the compare false.
  always_comb begin
    trial    = sar | (ONE << idx);
    vtrial   = VREFL + (VREFH - VREFL) * real'(trial) / real'(FULL);
    keep_bit = (vsamp >= vtrial);
    sar_next = keep_bit ? trial : sar;
  end

  // Sample/convert sequencer: reset first, EN low (or X) aborts, else run.
  always_ff @(posedge clk) begin
    if (reset == 1'b1) begin
      state <= IDLE;
      sar   <= '0;
      idx   <= IDX_MSB;
      vsamp <= 0.0;
      DATA  <= '0;
      VALID <= 1'b0;
      BUSY  <= 1'b0;
    end else if (EN == 1'b1) begin
      VALID <= 1'b0;
      case (state)
        IDLE: begin
          if (START == 1'b1) begin
            vsamp <= VIN;
            sar   <= '0;
            idx   <= IDX_MSB;
            BUSY  <= 1'b1;
            state <= CONV;
          end
        end
        CONV: begin
          if (idx == '0) begin
            DATA  <= sar_next;
            VALID <= 1'b1;
`ifdef ANALOG_ADC_CONT_EN
            // Back-to-back: next sample is taken on the same edge.
            vsamp <= VIN;
            sar   <= '0;
            idx   <= IDX_MSB;
            BUSY  <= 1'b1;
            state <= CONV;
`else
            sar   <= sar_next;
            BUSY  <= 1'b0;
            state <= IDLE;
`endif
          end else begin
            sar <= sar_next;
            idx <= idx - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end else begin
      // Abort discards the partial result; DATA keeps the last completion.
      state <= IDLE;
      sar   <= '0;
      idx   <= IDX_MSB;
      VALID <= 1'b0;
      BUSY  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_analog_sar_adc_3v3.sv
// Testbench for analog_sar_adc_3v3 (NBITS=10). Expected codes come from a
// reference model that searches for the largest code whose threshold voltage
// does not exceed the sampled input. Build with ANALOG_ADC_CONT_EN to
// exercise continuous mode.
module tb_analog_sar_adc_3v3;

  localparam int NBITS = 10;
  localparam int FULL  = 1 << NBITS;

  // ---------------- clock / reset / signals ----------------
  logic             clk = 1'b0;
  logic             reset;
  logic             EN;
  logic             START;
  real              VIN;
  real              VREFH;
  real              VREFL;
  logic [NBITS-1:0] DATA;
  logic             VALID;
  logic             BUSY;
  logic             dbg_state;

  always #5 clk = ~clk;

  analog_sar_adc_3v3 #(.NBITS(NBITS)) dut (
    .clk       (clk),
    .reset     (reset),
    .EN        (EN),
    .START     (START),
    .VIN       (VIN),
    .VREFH     (VREFH),
    .VREFL     (VREFL),
    .DATA      (DATA),
    .VALID     (VALID),
    .BUSY      (BUSY),
    .dbg_state (dbg_state)
  );

  int               checks = 0;
  int               errors = 0;
  logic [NBITS-1:0] exp_q[$];
  logic [NBITS-1:0] last_exp = '0;

  // ---------------- reference model ----------------
  function automatic logic [NBITS-1:0] model(input real vs, input real vh, input real vl);
    real span;
    logic [NBITS-1:0] ones;
    ones = '1;
    span = vh - vl;
    if (vs != vs || vh != vh || vl != vl) return '0;
    if (span <= 0.0) return (vs >= vl) ? ones : '0;
    for (int k = FULL - 1; k >= 1; k--) begin
      if (vs >= vl + span * real'(k) / real'(FULL)) return NBITS'(k);
    end
    return '0;
  endfunction

  // ---------------- driver / checker tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One conversion. chg_edge>0 switches VIN to vin2 after that edge;
  // pulse_edge>0 raises START for one cycle after that edge.
  task automatic run_conv(input string tag, input real vin, input int chg_edge,
                          input real vin2, input int pulse_edge);
    logic got;
    logic [NBITS-1:0] e;
    got = 1'b0;
    exp_q.push_back(model(vin, VREFH, VREFL));
    VIN   = vin;
    START = 1'b1;
    tick();
    START = 1'b0;
    check({tag, "_busy0"}, int'(BUSY), 1);
    for (int c = 1; c <= NBITS + 2 && !got; c++) begin
      tick();
      START = (c == pulse_edge) ? 1'b1 : 1'b0;
      if (c == chg_edge) VIN = vin2;
      if (VALID === 1'b1) begin
        got = 1'b1;
        check({tag, "_latency"}, c, NBITS);
        check({tag, "_busy_done"}, int'(BUSY), 0);
        if (exp_q.size() == 0) begin
          check({tag, "_sb_empty"}, 1, 0);
        end else begin
          e = exp_q.pop_front();
          check({tag, "_data"}, int'(DATA), int'(e));
          last_exp = e;
        end
      end else if (c < NBITS) begin
        check({tag, "_busy_mid"}, int'(BUSY), 1);
      end
    end
    if (!got) check({tag, "_timeout"}, 0, 1);
    START = 1'b0;
    tick();
    check({tag, "_valid_1cyc"}, int'(VALID), 0);
  endtask

  task automatic quiet_window(input string tag, input int n, input int exp_data);
    for (int i = 0; i < n; i++) begin
      tick();
      check({tag, "_valid"}, int'(VALID), 0);
      check({tag, "_busy"}, int'(BUSY), 0);
      check({tag, "_data"}, int'(DATA), exp_data);
    end
  endtask

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    real zero;
    real nan;
    zero  = 0.0;
    nan   = zero / zero;
    reset = 1'b1;
    EN    = 1'b0;
    START = 1'b0;
    VIN   = 0.0;
    VREFL = 0.0;
    VREFH = 3.3;

    // Reset for two cycles, then idle with EN=1 and no START.
    tick();
    tick();
    check("rst_data", int'(DATA), 0);
    check("rst_valid", int'(VALID), 0);
    check("rst_busy", int'(BUSY), 0);
    reset = 1'b0;
    EN    = 1'b1;
    quiet_window("idle", 20, 0);

`ifdef ANALOG_ADC_CONT_EN
    // Continuous mode: one START, VIN steps before the second sample edge.
    VIN   = 1.0;
    START = 1'b1;
    tick();
    START = 1'b0;
    check("cont_busy0", int'(BUSY), 1);
    for (int e = 1; e <= 30; e++) begin
      tick();
      if (e == 9) VIN = 2.0;
      check("cont_busy", int'(BUSY), 1);
      check("cont_valid", int'(VALID), (e % 10 == 0) ? 1 : 0);
      if (e == 10) check("cont_data1", int'(DATA), 310);
      if (e == 20) check("cont_data2", int'(DATA), 620);
      if (e == 30) check("cont_data3", int'(DATA), int'(model(2.0, 3.3, 0.0)));
    end
    EN = 1'b0;
    tick();
    check("cont_en_busy", int'(BUSY), 0);
    check("cont_en_valid", int'(VALID), 0);
    EN = 1'b1;
    quiet_window("cont_after_en", 5, 620);
`else
    // Nominal 1.0 V conversion, with a literal cross-check of the code.
    run_conv("v1p0", 1.0, 0, 0.0, 0);
    check("v1p0_lit", int'(DATA), 310);

    // Clamping above VREFH and below the first step.
    run_conv("v3p5", 3.5, 0, 0.0, 0);
    check("v3p5_lit", int'(DATA), 1023);
    run_conv("vneg", -0.2, 0, 0.0, 0);
    check("vneg_lit", int'(DATA), 0);

    // VIN moves mid-conversion; the sampled value must win.
    run_conv("vchg", 1.0, 3, 3.0, 0);
    check("vchg_lit", int'(DATA), 310);

    // START pulses while busy must not add conversions.
    run_conv("busy_start", 1.0, 0, 0.0, 4);
    START = 1'b0;
    VIN   = 1.0;
    tick();
    START = 1'b0;
    quiet_window("busy_start_after", 12, 310);

    // START held high: one completion every NBITS+1 edges.
    VIN   = 1.0;
    START = 1'b1;
    for (int e = 0; e <= 43; e++) begin
      tick();
      check("held_valid", int'(VALID), (e % 11 == 10) ? 1 : 0);
      check("held_busy", int'(BUSY), (e % 11 == 10) ? 0 : 1);
      if (e % 11 == 10) check("held_data", int'(DATA), 310);
      if (e == 43) START = 1'b0;
    end
    quiet_window("held_after", 3, 310);
    last_exp = 10'd310;

    // EN low at edge 5 aborts without touching DATA.
    VIN   = 2.0;
    START = 1'b1;
    tick();
    START = 1'b0;
    repeat (4) tick();
    EN = 1'b0;
    tick();
    check("abort_busy", int'(BUSY), 0);
    check("abort_valid", int'(VALID), 0);
    EN = 1'b1;
    quiet_window("abort_after", 15, int'(last_exp));

    // Reset at edge 5 clears everything, no VALID.
    VIN   = 2.0;
    START = 1'b1;
    tick();
    START = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst5_busy", int'(BUSY), 0);
    check("rst5_valid", int'(VALID), 0);
    check("rst5_data", int'(DATA), 0);
    quiet_window("rst5_after", 15, 0);
    last_exp = '0;

    // NaN and degenerate reference cases.
    run_conv("nan_vin", nan, 0, 0.0, 0);
    check("nan_vin_lit", int'(DATA), 0);
    run_conv("mid_after_nan", 1.0, 0, 0.0, 0);
    VREFH = nan;
    run_conv("nan_ref", 1.5, 0, 0.0, 0);
    check("nan_ref_lit", int'(DATA), 0);
    VREFH = 1.0;
    VREFL = 1.0;
    run_conv("flat_hi", 1.2, 0, 0.0, 0);
    check("flat_hi_lit", int'(DATA), 1023);
    run_conv("flat_lo", 0.8, 0, 0.0, 0);
    check("flat_lo_lit", int'(DATA), 0);
    VREFH = 0.5;
    VREFL = 2.0;
    run_conv("inv_hi", 2.5, 0, 0.0, 0);
    check("inv_hi_lit", int'(DATA), 1023);

    // Randomized references, inputs and idle gaps.
    for (int n = 0; n < 24; n++) begin
      VREFL = real'($urandom_range(0, 1000)) / 1000.0;
      VREFH = 2.0 + real'($urandom_range(0, 1300)) / 1000.0;
      run_conv("rand", -0.5 + real'($urandom_range(0, 4300)) / 1000.0, 0, 0.0, 0);
      repeat ($urandom_range(0, 3)) tick();
    end
    check("sb_drained", exp_q.size(), 0);
`endif

    // ---------------- final report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
